// File: rtl/button_gesture.sv
// ============================================================================
// Module      : button_gesture
// Description : Classifies a debounced button into short, long and double
//               presses using one shared cycle counter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module button_gesture #(
  parameter int unsigned long_threshold = 1000000,
  parameter int unsigned dbl_window     = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button_db,
  output logic       press_edge,
  output logic       short_press,
  output logic       long_press,
  output logic       double_press,
  output logic       held,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRESSED1  = 3'd1,
    S_LONG_HELD = 3'd2,
    S_WAIT2     = 3'd3,
    S_PRESSED2  = 3'd4
  } state_t;

  localparam logic [23:0] c_LONG_LAST = 24'(long_threshold - 1);
  localparam logic [23:0] c_DBL_LAST  = 24'(dbl_window - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [23:0] r_cnt;
  logic [23:0] w_cnt_nxt;
  logic        r_btn_prev;
  logic        r_press_edge;
  logic        r_short;
  logic        r_long;
  logic        r_double;
  logic        r_held;
  logic        w_press_edge_nxt;
  logic        w_short_nxt;
  logic        w_long_nxt;
  logic        w_double_nxt;
  logic        w_held_nxt;
  logic        w_rise;

  assign w_rise = button_db & ~r_btn_prev;

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_press_edge_nxt = 1'b0;
    w_short_nxt      = 1'b0;
    w_long_nxt       = 1'b0;
    w_double_nxt     = 1'b0;
    w_held_nxt       = r_held;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_state_nxt      = S_PRESSED1;
          w_cnt_nxt        = 24'd0;
          w_press_edge_nxt = 1'b1;
        end
      end
      S_PRESSED1: begin
        if (button_db) begin
          if (r_cnt == c_LONG_LAST) begin
            w_state_nxt = S_LONG_HELD;
            w_long_nxt  = 1'b1;
            w_held_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 24'd1;
          end
        end else begin
          w_state_nxt = S_WAIT2;
          w_cnt_nxt   = 24'd0;
        end
      end
      S_LONG_HELD: begin
        if (!button_db) begin
          w_state_nxt = S_IDLE;
          w_held_nxt  = 1'b0;
        end
      end
      S_WAIT2: begin
        // A press on the timeout edge is still a double press.
        if (button_db) begin
          w_state_nxt      = S_PRESSED2;
          w_double_nxt     = 1'b1;
          w_press_edge_nxt = 1'b1;
        end else if (r_cnt == c_DBL_LAST) begin
          w_state_nxt = S_IDLE;
          w_short_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 24'd1;
        end
      end
      S_PRESSED2: begin
        if (!button_db) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 24'd0;
        w_held_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 24'd0;
      r_btn_prev   <= 1'b0;
      r_press_edge <= 1'b0;
      r_short      <= 1'b0;
      r_long       <= 1'b0;
      r_double     <= 1'b0;
      r_held       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_btn_prev   <= button_db;
      r_press_edge <= w_press_edge_nxt;
      r_short      <= w_short_nxt;
      r_long       <= w_long_nxt;
      r_double     <= w_double_nxt;
      r_held       <= w_held_nxt;
    end
  end

  assign press_edge   = r_press_edge;
  assign short_press  = r_short;
  assign long_press   = r_long;
  assign double_press = r_double;
  assign held         = r_held;
  assign state_o      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_button_gesture.sv
// ============================================================================
// Module      : tb_button_gesture
// Description : Randomized and directed bench for button_gesture against a
//               timestamp-based gesture model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_button_gesture;

  localparam int LT = 8;
  localparam int DW = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       button_db = 1'b0;
  logic       press_edge, short_press, long_press, double_press, held;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  button_gesture #(.long_threshold(LT), .dbl_window(DW)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .button_db   (button_db),
    .press_edge  (press_edge),
    .short_press (short_press),
    .long_press  (long_press),
    .double_press(double_press),
    .held        (held),
    .state_o     (state_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Gesture model: phase codes follow the published debug encoding,
  // timing is derived from edge timestamps rather than a counter.
  int m_phase = 0;
  int m_t0    = 0;
  int m_trel  = 0;
  bit m_prev  = 1'b0;
  bit m_pe, m_sp, m_lp, m_dp, m_held;

  int n_pe, n_sp, n_lp, n_dp, n_held;
  int f_pe, l_pe, f_sp, f_lp, f_dp, mf_sp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, exp_v);
    end
  endtask

  task automatic clear_obs();
    n_pe = 0; n_sp = 0; n_lp = 0; n_dp = 0; n_held = 0;
    f_pe = -1; l_pe = -1; f_sp = -1; f_lp = -1; f_dp = -1; mf_sp = -1;
  endtask

  // Inputs set here are consumed by the edge numbered cyc+1.
  task automatic apply(input bit b, input bit r);
    button_db = b;
    reset     = r;
    @(negedge clk);
  endtask

  initial begin
    clear_obs();
    forever begin
      @(posedge clk);
      cyc++;
      m_pe = 0; m_sp = 0; m_lp = 0; m_dp = 0;
      if (reset) begin
        m_phase = 0;
        m_prev  = 0;
        m_held  = 0;
      end else begin
        case (m_phase)
          0: if (button_db && !m_prev) begin m_phase = 1; m_t0 = cyc; m_pe = 1; end
          1: begin
            if (button_db) begin
              if (cyc - m_t0 == LT) begin m_phase = 2; m_lp = 1; end
            end else begin
              m_phase = 3; m_trel = cyc;
            end
          end
          2: if (!button_db) m_phase = 0;
          3: begin
            if (button_db) begin m_phase = 4; m_dp = 1; m_pe = 1; end
            else if (cyc - m_trel == DW) begin m_phase = 0; m_sp = 1; end
          end
          4: if (!button_db) m_phase = 0;
          default: m_phase = 0;
        endcase
        m_prev = button_db;
        m_held = (m_phase == 2);
      end
      #1;
      chk("press_edge", {31'd0, press_edge}, {31'd0, m_pe});
      chk("short_press", {31'd0, short_press}, {31'd0, m_sp});
      chk("long_press", {31'd0, long_press}, {31'd0, m_lp});
      chk("double_press", {31'd0, double_press}, {31'd0, m_dp});
      chk("held", {31'd0, held}, {31'd0, m_held});
      chk("state_o", {29'd0, state_o}, m_phase);
      if (press_edge === 1'b1) begin n_pe++; if (f_pe < 0) f_pe = cyc; l_pe = cyc; end
      if (short_press === 1'b1) begin n_sp++; if (f_sp < 0) f_sp = cyc; end
      if (long_press === 1'b1) begin n_lp++; if (f_lp < 0) f_lp = cyc; end
      if (double_press === 1'b1) begin n_dp++; if (f_dp < 0) f_dp = cyc; end
      if (held === 1'b1) n_held++;
      if (m_sp && mf_sp < 0) mf_sp = cyc;
    end
  end

  initial begin
    int e, r, d, p, x;
    apply(0, 1);
    apply(0, 1);
    chk("reset_outputs", {26'd0, press_edge, short_press, long_press, double_press, held, state_o}, 0);
    apply(0, 0);
    apply(0, 0);

    // Short press
    clear_obs();
    e = cyc + 1;
    repeat (3) apply(1, 0);
    r = cyc + 1;
    repeat (8) apply(0, 0);
    chk("short_pe_count", n_pe, 1);
    chk("short_pe_edge", f_pe, e);
    chk("short_sp_count", n_sp, 1);
    chk("short_sp_edge", f_sp, r + 5);
    chk("short_model_sp_edge", mf_sp, r + 5);
    chk("short_other_pulses", n_lp + n_dp, 0);

    // Long press
    clear_obs();
    e = cyc + 1;
    repeat (20) apply(1, 0);
    repeat (8) apply(0, 0);
    chk("long_lp_count", n_lp, 1);
    chk("long_lp_edge", f_lp, e + 8);
    chk("long_held_cycles", n_held, 12);
    chk("long_no_short", n_sp, 0);
    chk("long_idle_state", {29'd0, state_o}, 0);

    // Long threshold boundary: one edge short of long
    clear_obs();
    e = cyc + 1;
    repeat (8) apply(1, 0);
    repeat (8) apply(0, 0);
    chk("lbound_no_long", n_lp, 0);
    chk("lbound_sp_edge", f_sp, e + 13);

    // Second press exactly on the window timeout edge
    clear_obs();
    repeat (3) apply(1, 0);
    r = cyc + 1;
    repeat (5) apply(0, 0);
    d = cyc + 1;
    repeat (3) apply(1, 0);
    repeat (8) apply(0, 0);
    chk("dbl_count", n_dp, 1);
    chk("dbl_edge", f_dp, r + 5);
    chk("dbl_no_short", n_sp, 0);
    chk("dbl_pe_count", n_pe, 2);
    chk("dbl_pe_last", l_pe, d);

    // Second press one edge too late
    clear_obs();
    repeat (3) apply(1, 0);
    r = cyc + 1;
    repeat (6) apply(0, 0);
    p = cyc + 1;
    repeat (2) apply(1, 0);
    repeat (10) apply(0, 0);
    chk("late_sp_edge", f_sp, r + 5);
    chk("late_pe_last", l_pe, p);
    chk("late_no_double", n_dp, 0);
    chk("late_sp_count", n_sp, 2);

    // Reset while in LONG_HELD with the button still down
    clear_obs();
    repeat (10) apply(1, 0);
    chk("rst_long_held_before", {31'd0, held}, 1);
    x = cyc + 1;
    apply(1, 1);
    chk("rst_held_cleared", {31'd0, held}, 0);
    apply(1, 0);
    chk("rst_repress_edge", {31'd0, press_edge}, 1);
    chk("rst_repress_state", {29'd0, state_o}, 1);
    chk("rst_repress_at", l_pe, x + 1);
    repeat (2) apply(1, 0);
    repeat (10) apply(0, 0);

    // Random gestures with occasional resets
    repeat (300) begin
      bit lvl;
      lvl = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) begin
        repeat ($urandom_range(1, 2)) apply(lvl, 1);
      end else begin
        repeat ($urandom_range(1, 12)) apply(lvl, 0);
      end
    end
    repeat (20) apply(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/button_gesture.md
BUTTON_GESTURE -- requirements
Module: button_gesture

Interface
REQ-001 Parameter long_threshold, default 1000000: consecutive high cycles after the press edge that classify a press as long; legal range 2..2^24-1.
REQ-002 Parameter dbl_window, default 500000: cycles after release within which a second press makes a double press; legal range 2..2^24-1.
REQ-003 Port clk, input, 1: sole clock; all registers update on its rising edge.
REQ-004 Port reset, input, 1: reset is synchronous and active-high.
REQ-005 Port button_db, input, 1: debounced button level, already synchronous to clk.
REQ-006 Port press_edge, output, 1: one-cycle pulse on every detected rising edge of button_db.
REQ-007 Port short_press, output, 1: one-cycle pulse marking a completed single short press.
REQ-008 Port long_press, output, 1: one-cycle pulse marking long-press detection.
REQ-009 Port double_press, output, 1: one-cycle pulse marking a second press inside the window.
REQ-010 Port held, output, 1: level, high while in LONG_HELD.
REQ-011 Port state_o, output, 3: current state encoding, for debug.

Function
REQ-012 Rising edge is defined as button_db sampled 1 with the registered previous sample (btn_prev) at 0; btn_prev updates every cycle.
REQ-013 All outputs are registered, so there is no combinational path from button_db to any output.
REQ-014 A single 24-bit counter (cnt) serves all states; it never wraps, because each state exits before cnt reaches its parameter.
REQ-015 The FSM has the states IDLE=0, PRESSED1=1, LONG_HELD=2, WAIT2=3 and PRESSED2=4; the codes 5-7 go to IDLE on the next edge.
REQ-016 In IDLE, a rising edge -> PRESSED1, cnt<=0, press_edge<=1.
REQ-017 In PRESSED1 with button_db=1 and cnt==long_threshold-1 -> LONG_HELD, long_press<=1, held<=1; otherwise with button_db=1 -> cnt<=cnt+1.
REQ-018 In PRESSED1 with button_db=0 -> WAIT2, cnt<=0.
REQ-019 Timing: with press edge E, long_press is high in the cycle after edge E+long_threshold, provided button_db was sampled 1 on every edge E..E+long_threshold.
REQ-020 In LONG_HELD, held stays 1; button_db=0 -> IDLE and held<=0; no short_press or double_press follows.
REQ-021 In WAIT2 with button_db=1 -> PRESSED2, double_press<=1, press_edge<=1.
REQ-022 In WAIT2 with button_db=0 and cnt==dbl_window-1 -> IDLE, short_press<=1; otherwise -> cnt<=cnt+1.
REQ-023 Timing: with release edge R, short_press is high after edge R+dbl_window.
REQ-024 When a press and the timeout fall on the same WAIT2 edge, the press wins: the result is double_press and no short_press.
REQ-025 In PRESSED2 with button_db=0 -> IDLE; no long detection applies to the second press.
REQ-026 At most one of short_press, long_press and double_press is high in any cycle; press_edge may coincide only with double_press.

Reset
REQ-027 With reset=1 at an edge: state=IDLE, cnt=0, btn_prev=0, and all outputs are 0.
REQ-028 Reset overrides all FSM activity, including mid-press or mid-window, and any pending event is discarded.
REQ-029 Because btn_prev resets to 0, a button_db still high at reset release is treated as a new press edge on the first edge after reset.

Verification (long_threshold=8, dbl_window=5)
REQ-030 Reset: assert reset for 2 cycles with button_db=0 -> all outputs 0 and state_o=0.
REQ-031 Short press: high for 3 edges, then low -> one press_edge pulse, short_press pulse after edge R+5, no other pulses.
REQ-032 Long press: high for 20 edges -> long_press after edge E+8, held 1 until the release edge, state back to IDLE, no short_press.
REQ-033 Long boundary: high for exactly 8 edges E..E+7, low at E+8 -> no long_press, short_press after edge E+8+5.
REQ-034 Double boundary: release at R, next rise sampled at R+5 -> double_press with no short_press; rise at R+6 instead -> short_press after R+5, then press_edge after R+6.
REQ-035 Reset mid-LONG_HELD with button_db held 1 -> held 0 after the reset edge, then press_edge and PRESSED1 on the first non-reset edge.
